// File: rtl/io_arbiter_rr.sv
// io_arbiter_rr: round-robin N-channel arbiter with registered valid/ready output stage and hold watchdog
module io_arbiter_rr #(
  parameter int NUM_CH = 2,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int TO_CYC = 255,
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_CH-1:0]        req,
  input  logic [NUM_CH*DATA_W-1:0] datos_in,
  input  logic [NUM_CH*ADDR_W-1:0] dir_in,
  output logic [NUM_CH-1:0]        ack,
  output logic [DATA_W-1:0]        datos_out,
  output logic [ADDR_W-1:0]        dir_out,
  output logic [CH_W-1:0]          ch_id,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     estado_in,
  output logic                     busy,
  output logic                     to_err
);
  localparam int CNT_W = (TO_CYC > 1) ? $clog2(TO_CYC) : 1;
  localparam int TO_M1 = (TO_CYC > 0) ? TO_CYC - 1 : 0;
  typedef enum logic {IDLE, HOLD} state_t;
  state_t state;
  logic [CH_W-1:0] last, grant;
  logic [CNT_W-1:0] cnt;
  logic [DATA_W-1:0] d_sel;
  logic [ADDR_W-1:0] a_sel;
  logic found;
  assign estado_in = |req;
  always_comb begin
    grant = '0;
    found = 1'b0;
    d_sel = '0;
    a_sel = '0;
    for (int i = 1; i <= NUM_CH; i++)
      if (!found && req[CH_W'((int'(last) + i) % NUM_CH)]) begin
        grant = CH_W'((int'(last) + i) % NUM_CH);
        found = 1'b1;
      end
    for (int i = 0; i < NUM_CH; i++)
      if (grant == CH_W'(i)) begin
        d_sel = datos_in[i*DATA_W +: DATA_W];
        a_sel = dir_in[i*ADDR_W +: ADDR_W];
      end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state     <= IDLE;
      last      <= CH_W'(NUM_CH - 1);
      cnt       <= '0;
      ack       <= '0;
      datos_out <= '0;
      dir_out   <= '0;
      ch_id     <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      to_err    <= 1'b0;
    end else begin
      ack    <= '0;
      to_err <= 1'b0;
      if (state == IDLE) begin
        if (found) begin
          datos_out <= d_sel;
          dir_out   <= a_sel;
          ch_id     <= grant;
          out_valid <= 1'b1;
          busy      <= 1'b1;
          cnt       <= '0;
          state     <= HOLD;
        end
      end else if (out_ready) begin
        ack[ch_id] <= 1'b1;
        out_valid  <= 1'b0;
        busy       <= 1'b0;
        last       <= ch_id;
        state      <= IDLE;
      end else if (TO_CYC > 0 && cnt == CNT_W'(TO_M1)) begin
        to_err    <= 1'b1;
        out_valid <= 1'b0;
        busy      <= 1'b0;
        last      <= ch_id;
        state     <= IDLE;
      end else
        cnt <= cnt + 1'b1;
    end
endmodule

// File: tb/tb_io_arbiter_rr.sv
// tb_io_arbiter_rr: table-driven and scoreboard bench for io_arbiter_rr
module tb_io_arbiter_rr;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;
  logic [3:0] req4 = '0, reqw = '0, ack4, ackw;
  logic [127:0] din4 = '0, adr4 = '0;
  logic [31:0] dout4, aout4, doutw, aoutw;
  logic [1:0] ch4, chw;
  logic ov4, rdy4 = 1'b0, est4, busy4, te4;
  logic ovw, rdyw = 1'b0, estw, busyw, tew;
  logic [1:0] req2 = '0, ack2;
  logic [63:0] din2 = '0, adr2 = '0;
  logic [31:0] dout2, aout2;
  logic ch2, ov2, rdy2 = 1'b0, est2, busy2, te2;
  io_arbiter_rr #(.NUM_CH(4), .TO_CYC(255)) u4 (
    .clk(clk), .rst_n(rst_n), .req(req4), .datos_in(din4), .dir_in(adr4), .ack(ack4),
    .datos_out(dout4), .dir_out(aout4), .ch_id(ch4), .out_valid(ov4), .out_ready(rdy4),
    .estado_in(est4), .busy(busy4), .to_err(te4));
  io_arbiter_rr #(.NUM_CH(4), .TO_CYC(8)) uw (
    .clk(clk), .rst_n(rst_n), .req(reqw), .datos_in(din4), .dir_in(adr4), .ack(ackw),
    .datos_out(doutw), .dir_out(aoutw), .ch_id(chw), .out_valid(ovw), .out_ready(rdyw),
    .estado_in(estw), .busy(busyw), .to_err(tew));
  io_arbiter_rr #(.NUM_CH(2), .TO_CYC(0)) u2 (
    .clk(clk), .rst_n(rst_n), .req(req2), .datos_in(din2), .dir_in(adr2), .ack(ack2),
    .datos_out(dout2), .dir_out(aout2), .ch_id(ch2), .out_valid(ov2), .out_ready(rdy2),
    .estado_in(est2), .busy(busy2), .to_err(te2));
  int n_tests = 0, n_fail = 0;
  typedef struct { logic [3:0] req; int ch; } vec_t;
  typedef struct { logic [1:0] ch; logic [31:0] d; logic [31:0] a; } exp_t;
  vec_t tbl[13];
  exp_t sb[$];
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  function automatic logic [31:0] dv(input int ch, input int k);
    return 32'hD000_0000 | 32'(ch << 8) | 32'(k);
  endfunction
  function automatic logic [31:0] av(input int ch, input int k);
    return 32'(32'h1000 * (ch + 1) + k);
  endfunction
  task automatic set4(input int k);
    for (int c = 0; c < 4; c++) begin
      din4[c*32 +: 32] = dv(c, k);
      adr4[c*32 +: 32] = av(c, k);
    end
  endtask
  task automatic push(input int ch, input int k);
    exp_t e;
    e.ch = 2'(ch);
    e.d = dv(ch, k);
    e.a = av(ch, k);
    sb.push_back(e);
  endtask
  always @(negedge clk)
    if (ov4 && rdy4) begin
      if (sb.size() == 0) chk("sb_underflow", 1, 0);
      else begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_ch", ch4, e.ch);
        chk("sb_data", dout4, e.d);
        chk("sb_addr", aout4, e.a);
      end
    end
  initial begin
    tbl[0] = '{4'b1111, 0}; tbl[1] = '{4'b1111, 1}; tbl[2] = '{4'b1111, 2};
    tbl[3] = '{4'b1111, 3}; tbl[4] = '{4'b1111, 0}; tbl[5] = '{4'b1010, 1};
    tbl[6] = '{4'b1010, 3}; tbl[7] = '{4'b1010, 1}; tbl[8] = '{4'b0001, 0};
    tbl[9] = '{4'b1000, 3}; tbl[10] = '{4'b0100, 2}; tbl[11] = '{4'b0110, 1};
    tbl[12] = '{4'b0110, 2};
    req2 = 2'b11;
    rdy2 = 1'b1;
    #2 rst_n = 1'b0;
    tick();
    tick();
    chk("rst_valid", ov2, 0);
    chk("rst_ack", ack2, 0);
    chk("rst_to_err", te2, 0);
    chk("rst_busy", busy2, 0);
    chk("rst_estado", est2, 1);
    chk("rst_estado_idle", est4, 0);
    chk("rst_dout", dout2, 0);
    rst_n = 1'b1;
    tick();
    chk("rst_first_valid", ov2, 1);
    chk("rst_first_ch", ch2, 0);
    tick();
    chk("rst_first_ack", ack2, 2'b01);
    req2 = 2'b10;
    din2 = {32'hA5A5_0001, 32'h1111_1111};
    adr2 = {32'h0000_1000, 32'h0000_2222};
    tick();
    chk("single_valid", ov2, 1);
    chk("single_ch", ch2, 1);
    chk("single_dout", dout2, 32'hA5A5_0001);
    chk("single_aout", aout2, 32'h0000_1000);
    chk("single_noack", ack2, 0);
    tick();
    chk("single_ack", ack2, 2'b10);
    chk("single_drop", ov2, 0);
    tick();
    chk("single_regrant", ov2, 1);
    chk("single_ack_pulse", ack2, 0);
    req2 = 2'b00;
    tick();
    chk("single_ack2", ack2, 2'b10);
    tick();
    chk("single_idle", ov2, 0);
    chk("single_ack_clear", ack2, 0);
    rdy4 = 1'b1;
    for (int k = 0; k < 13; k++) begin
      req4 = tbl[k].req;
      set4(k);
      push(tbl[k].ch, k);
      tick();
      chk("tbl_valid", ov4, 1);
      chk("tbl_ch", ch4, tbl[k].ch);
      chk("tbl_busy", busy4, 1);
      tick();
      chk("tbl_ack", ack4, 64'(1 << tbl[k].ch));
      chk("tbl_drop", ov4, 0);
    end
    req4 = 4'b0100;
    rdy4 = 1'b0;
    set4(100);
    push(2, 100);
    tick();
    chk("bp_valid", ov4, 1);
    chk("bp_ch", ch4, 2);
    for (int i = 0; i < 10; i++) begin
      set4(200 + i);
      tick();
      chk("bp_dout", dout4, dv(2, 100));
      chk("bp_aout", aout4, av(2, 100));
      chk("bp_ch_hold", ch4, 2);
      chk("bp_busy", busy4, 1);
      chk("bp_noack", ack4, 0);
    end
    rdy4 = 1'b1;
    tick();
    chk("bp_ack", ack4, 4'b0100);
    chk("bp_drop", ov4, 0);
    req4 = 4'b0000;
    tick();
    chk("bp_ack_pulse", ack4, 0);
    reqw = 4'b0010;
    tick();
    chk("wd_valid", ovw, 1);
    chk("wd_ch", chw, 1);
    for (int i = 1; i < 8; i++) begin
      tick();
      chk("wd_hold", ovw, 1);
      chk("wd_no_err", tew, 0);
    end
    tick();
    chk("wd_drop", ovw, 0);
    chk("wd_err", tew, 1);
    chk("wd_noack", ackw, 0);
    chk("wd_busy", busyw, 0);
    reqw = 4'b0011;
    tick();
    chk("wd_err_pulse", tew, 0);
    chk("wd_regrant", ovw, 1);
    chk("wd_rotate", chw, 0);
    for (int i = 0; i < 7; i++) tick();
    rdyw = 1'b1;
    reqw = 4'b0000;
    tick();
    chk("wd_hs_wins_ack", ackw, 4'b0001);
    chk("wd_hs_wins_err", tew, 0);
    tick();
    chk("wd_hs_after", tew, 0);
    rdy2 = 1'b0;
    req2 = 2'b01;
    tick();
    chk("to0_valid", ov2, 1);
    for (int i = 0; i < 110; i++) begin
      tick();
      chk("to0_hold", ov2, 1);
      chk("to0_no_err", te2, 0);
    end
    rdy2 = 1'b1;
    req2 = 2'b00;
    tick();
    chk("to0_ack", ack2, 2'b01);
    rdy4 = 1'b0;
    req4 = 4'b0001;
    set4(250);
    tick();
    chk("mr_valid", ov4, 1);
    chk("mr_ch", ch4, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("mr_async_valid", ov4, 0);
    chk("mr_async_busy", busy4, 0);
    chk("mr_async_dout", dout4, 0);
    tick();
    chk("mr_noack", ack4, 0);
    req4 = 4'b0100;
    set4(300);
    push(2, 300);
    rdy4 = 1'b1;
    rst_n = 1'b1;
    tick();
    chk("mr_regrant", ov4, 1);
    chk("mr_ch2", ch4, 2);
    tick();
    chk("mr_ack", ack4, 4'b0100);
    req4 = 4'b0000;
    tick();
    chk("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
